stream_in_byte_packer: RTL and testbench

STREAM_IN_BYTE_PACKER -- requirements
Module: stream_in_byte_packer

---
 rtl/stream_in_byte_packer.sv | 136 +++++++++++++
 tb/tb_stream_in_byte_packer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_in_byte_packer.sv
// Byte-to-word packer feeding a 32-bit FIFO that is drained by an FX3
// slave-FIFO writer. Bytes are packed little-endian; a word is committed
// when its fourth byte arrives or when a byte marked last arrives, in which
// case the unwritten upper lanes are filled with PAD_BYTE.
module stream_in_byte_packer #(
  parameter int unsigned DEPTH    = 16,
  parameter logic [7:0]  PAD_BYTE = 8'h00
) (
  input  logic                     clk_100,
  input  logic                     reset,
  input  logic                     stream_in_mode_selected,
  input  logic [7:0]               byte_in,
  input  logic                     byte_valid,
  input  logic                     byte_last,
  output logic                     byte_ready,
  input  logic                     slwr_streamIN_,
  output logic [31:0]              data_for_output,
  output logic                     word_avail,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     drop_sticky,
  output logic                     underflow_sticky
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic {
    PK_EMPTY,
    PK_PARTIAL
  } pk_state_t;

  pk_state_t       state_q;
  logic [1:0]      lane_q, lane_d;
  logic [31:0]     word_q, word_d;
  logic [31:0]     commit_word;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q, level_d;
  logic            drop_q, unf_q;
  logic [31:0]     mem_q [DEPTH];

  logic            full;
  logic            accept;
  logic            push;
  logic            pop;

  // Handshake, packing datapath and next-state values
  always_comb begin
    full       = (level_q == LW'(DEPTH));
    word_avail = (level_q != '0);
    // Depends only on registered occupancy and the mode input, never on the
    // write strobe; reset forces it low without waiting for an edge.
    byte_ready = !reset && stream_in_mode_selected && !full;
    accept     = byte_valid && byte_ready;
    push       = accept && ((lane_q == 2'd3) || byte_last);
    pop        = !slwr_streamIN_ && word_avail;

    word_d      = word_q;
    commit_word = word_q;
    for (int unsigned i = 0; i < 4; i++) begin
      if (i == 32'(lane_q)) begin
        word_d[8*i +: 8]      = byte_in;
        commit_word[8*i +: 8] = byte_in;
      end else if (i > 32'(lane_q)) begin
        commit_word[8*i +: 8] = PAD_BYTE;
      end
    end
    lane_d = lane_q + 2'd1;

    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    data_for_output  = word_avail ? mem_q[rd_ptr_q] : '0;
    fifo_level       = level_q;
    drop_sticky      = drop_q;
    underflow_sticky = unf_q;
  end

  // Packer FSM, FIFO pointers/occupancy and sticky error flags
  always_ff @(posedge clk_100 or posedge reset) begin
    if (reset) begin
      state_q  <= PK_EMPTY;
      lane_q   <= '0;
      word_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      drop_q   <= 1'b0;
      unf_q    <= 1'b0;
    end else if (!stream_in_mode_selected) begin
      // Mode deassert wins over any commit or pop in the same cycle.
      state_q  <= PK_EMPTY;
      lane_q   <= '0;
      word_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      drop_q   <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      if (accept) begin
        if (push) begin
          state_q  <= PK_EMPTY;
          lane_q   <= '0;
          word_q   <= '0;
          wr_ptr_q <= wr_ptr_q + 1'b1;
        end else begin
          state_q <= PK_PARTIAL;
          lane_q  <= lane_d;
          word_q  <= word_d;
        end
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      level_q <= level_d;
      if (byte_valid && !byte_ready) begin
        drop_q <= 1'b1;
      end
      if (!slwr_streamIN_ && !word_avail) begin
        unf_q <= 1'b1;
      end
    end
  end

  // FIFO storage; contents need no reset since occupancy gates visibility
  always_ff @(posedge clk_100) begin
    if (push) begin
      mem_q[wr_ptr_q] <= commit_word;
    end
  end

endmodule

// File: tb/tb_stream_in_byte_packer.sv
// Self-checking bench for stream_in_byte_packer: directed scenarios plus
// randomized traffic, all compared against a queue-based reference model.
module tb_stream_in_byte_packer;

  localparam int         DEPTH = 16;
  localparam int         LW    = $clog2(DEPTH) + 1;
  localparam logic [7:0] PAD   = 8'h00;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          mode = 1'b0;
  logic [7:0]    b_in = '0;
  logic          b_valid = 1'b0;
  logic          b_last = 1'b0;
  logic          b_ready;
  logic          slwr = 1'b1;
  logic [31:0]   dout;
  logic          avail;
  logic [LW-1:0] level;
  logic          drop;
  logic          unf;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic [31:0] m_q[$];
  logic [7:0]  m_bytes[$];
  bit          m_drop = 0;
  bit          m_unf  = 0;
  bit          m_mode = 0;

  logic [31:0] full_words [DEPTH];

  stream_in_byte_packer #(.DEPTH(DEPTH), .PAD_BYTE(PAD)) dut (
    .clk_100                (clk),
    .reset                  (rst),
    .stream_in_mode_selected(mode),
    .byte_in                (b_in),
    .byte_valid             (b_valid),
    .byte_last              (b_last),
    .byte_ready             (b_ready),
    .slwr_streamIN_         (slwr),
    .data_for_output        (dout),
    .word_avail             (avail),
    .fifo_level             (level),
    .drop_sticky            (drop),
    .underflow_sticky       (unf)
  );

  always #5 clk = ~clk;

  function automatic logic [LW-1:0] exp_level();
    return LW'(m_q.size());
  endfunction

  function automatic logic [31:0] exp_data();
    return (m_q.size() > 0) ? m_q[0] : 32'h0;
  endfunction

  function automatic logic exp_ready();
    return !rst && m_mode && (m_q.size() != DEPTH);
  endfunction

  function automatic void model_clear();
    m_q.delete();
    m_bytes.delete();
    m_drop = 0;
    m_unf  = 0;
  endfunction

  // Apply one cycle of inputs, advance the model across the edge, and
  // return at posedge+1 with the inputs still held.
  task automatic drive_cycle(input bit md, input bit v, input logic [7:0] b,
                             input bit lst, input bit wr_n);
    bit rdy;
    logic [31:0] w;
    mode = md; b_valid = v; b_in = b; b_last = lst; slwr = wr_n;
    m_mode = md;
    if (rst || !md) begin
      model_clear();
    end else begin
      rdy = (m_q.size() != DEPTH);
      if (!wr_n && m_q.size() == 0) m_unf = 1;
      if (v && !rdy) m_drop = 1;
      if (!wr_n && m_q.size() > 0) void'(m_q.pop_front());
      if (v && rdy) begin
        m_bytes.push_back(b);
        if (lst || m_bytes.size() == 4) begin
          w = {4{PAD}};
          for (int k = 0; k < m_bytes.size(); k++) w[8*k +: 8] = m_bytes[k];
          m_q.push_back(w);
          m_bytes.delete();
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    mode = 1'b1;
    m_mode = 1'b1;
    model_clear();
    #1;
    n_cmp++; if (avail !== 1'b0) begin n_err++; $display("FAIL reset_avail: got %b want 0", avail); end
    n_cmp++; if (dout !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h want 00000000", dout); end
    n_cmp++; if (b_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", b_ready); end
    n_cmp++; if (level !== '0) begin n_err++; $display("FAIL reset_level: got %0d want 0", level); end
    n_cmp++; if (drop !== 1'b0 || unf !== 1'b0) begin n_err++; $display("FAIL reset_sticky: got %b%b want 00", drop, unf); end
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    n_cmp++; if (b_ready !== 1'b1) begin n_err++; $display("FAIL release_ready: got %b want 1", b_ready); end
  endtask

  task automatic test_pack_basic();
    logic [7:0] bs [4];
    bs[0] = 8'h11; bs[1] = 8'h22; bs[2] = 8'h33; bs[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1, 1, bs[i], 0, 1);
      n_cmp++; if (avail !== (i == 3)) begin n_err++; $display("FAIL pack_avail%0d: got %b want %b", i, avail, (i == 3)); end
    end
    drive_cycle(1, 0, 8'h00, 0, 1);
    n_cmp++; if (dout !== 32'h44332211) begin n_err++; $display("FAIL pack_data: got %h want 44332211", dout); end
    n_cmp++; if (level !== LW'(1)) begin n_err++; $display("FAIL pack_level: got %0d want 1", level); end
    drive_cycle(1, 0, 8'h00, 0, 0);
    n_cmp++; if (avail !== 1'b0 || dout !== 32'h0) begin n_err++; $display("FAIL pack_pop: got avail=%b data=%h want 0/00000000", avail, dout); end
  endtask

  task automatic test_last_pad();
    drive_cycle(1, 1, 8'hAA, 0, 1);
    drive_cycle(1, 1, 8'hBB, 1, 1);
    n_cmp++; if (dout !== 32'h0000BBAA) begin n_err++; $display("FAIL pad_data: got %h want 0000bbaa", dout); end
    drive_cycle(1, 1, 8'hCC, 1, 0);
    n_cmp++; if (dout !== 32'h000000CC) begin n_err++; $display("FAIL pad_lane0: got %h want 000000cc", dout); end
    n_cmp++; if (level !== LW'(1)) begin n_err++; $display("FAIL pad_level: got %0d want 1", level); end
    drive_cycle(1, 0, 8'h00, 0, 0);
    n_cmp++; if (level !== exp_level()) begin n_err++; $display("FAIL pad_drain: got %0d want %0d", level, exp_level()); end
  endtask

  task automatic test_full_drop();
    logic [7:0] b;
    drive_cycle(0, 0, 8'h00, 0, 1);
    for (int i = 0; i < 4 * DEPTH; i++) begin
      b = 8'($urandom);
      full_words[i / 4][8*(i % 4) +: 8] = b;
      drive_cycle(1, 1, b, 0, 1);
    end
    n_cmp++; if (level !== LW'(DEPTH)) begin n_err++; $display("FAIL full_level: got %0d want %0d", level, DEPTH); end
    n_cmp++; if (b_ready !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b want 0", b_ready); end
    n_cmp++; if (dout !== full_words[0]) begin n_err++; $display("FAIL full_head: got %h want %h", dout, full_words[0]); end
    drive_cycle(1, 1, 8'h5A, 0, 1);
    n_cmp++; if (drop !== 1'b1) begin n_err++; $display("FAIL drop_set: got %b want 1", drop); end
    n_cmp++; if (level !== LW'(DEPTH) || dout !== full_words[0]) begin n_err++; $display("FAIL drop_unchanged: got level=%0d data=%h want %0d/%h", level, dout, DEPTH, full_words[0]); end
  endtask

  task automatic test_commit_pop();
    drive_cycle(1, 0, 8'h00, 0, 0);
    n_cmp++; if (level !== LW'(DEPTH - 1) || dout !== full_words[1]) begin n_err++; $display("FAIL cp_pop: got level=%0d data=%h want %0d/%h", level, dout, DEPTH - 1, full_words[1]); end
    drive_cycle(1, 1, 8'h01, 0, 1);
    drive_cycle(1, 1, 8'h02, 0, 1);
    drive_cycle(1, 1, 8'h03, 0, 1);
    drive_cycle(1, 1, 8'h04, 0, 0);
    n_cmp++; if (level !== LW'(DEPTH - 1)) begin n_err++; $display("FAIL cp_level: got %0d want %0d", level, DEPTH - 1); end
    n_cmp++; if (dout !== full_words[2]) begin n_err++; $display("FAIL cp_head: got %h want %h", dout, full_words[2]); end
    for (int i = 0; i < 4; i++) drive_cycle(1, 1, 8'(8'h10 + i), 0, 1);
    n_cmp++; if (level !== LW'(DEPTH)) begin n_err++; $display("FAIL cp_refill: got %0d want %0d", level, DEPTH); end
    // full: a byte offered alongside a pop is refused, the pop still happens
    drive_cycle(1, 1, 8'h77, 0, 0);
    n_cmp++; if (level !== LW'(DEPTH - 1) || dout !== full_words[3]) begin n_err++; $display("FAIL cp_fullpop: got level=%0d data=%h want %0d/%h", level, dout, DEPTH - 1, full_words[3]); end
    n_cmp++; if (drop !== 1'b1) begin n_err++; $display("FAIL cp_drop: got %b want 1", drop); end
  endtask

  task automatic test_underflow_mode();
    drive_cycle(0, 0, 8'h00, 0, 1);
    n_cmp++; if (level !== '0 || drop !== 1'b0) begin n_err++; $display("FAIL mode_clear: got level=%0d drop=%b want 0/0", level, drop); end
    drive_cycle(1, 0, 8'h00, 0, 0);
    n_cmp++; if (unf !== 1'b1) begin n_err++; $display("FAIL unf_set: got %b want 1", unf); end
    n_cmp++; if (level !== '0 || avail !== 1'b0) begin n_err++; $display("FAIL unf_level: got level=%0d avail=%b want 0/0", level, avail); end
    drive_cycle(1, 1, 8'h99, 0, 1);
    drive_cycle(0, 1, 8'h98, 0, 0);
    n_cmp++; if (drop !== 1'b0 || unf !== 1'b0) begin n_err++; $display("FAIL mode_sticky: got %b%b want 00", drop, unf); end
    drive_cycle(1, 1, 8'h01, 0, 1);
    drive_cycle(1, 1, 8'h02, 1, 1);
    n_cmp++; if (dout !== 32'h00000201) begin n_err++; $display("FAIL mode_partial_lost: got %h want 00000201", dout); end
  endtask

  task automatic test_reset_midword();
    drive_cycle(0, 0, 8'h00, 0, 1);
    drive_cycle(1, 1, 8'hE1, 0, 1);
    drive_cycle(1, 1, 8'hE2, 0, 1);
    drive_cycle(1, 1, 8'hE3, 0, 1);
    drive_cycle(1, 1, 8'hE4, 0, 1);
    drive_cycle(1, 1, 8'hE5, 0, 1);
    drive_cycle(1, 1, 8'hE6, 0, 0);
    b_valid = 1'b0;
    #2 rst = 1'b1;
    model_clear();
    #1;
    n_cmp++; if (avail !== 1'b0 || dout !== 32'h0 || level !== '0) begin n_err++; $display("FAIL rst_async: got avail=%b data=%h level=%0d want 0/0/0", avail, dout, level); end
    n_cmp++; if (b_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b want 0", b_ready); end
    drive_cycle(1, 0, 8'h00, 0, 1);
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) drive_cycle(1, 1, 8'(i), 0, 1);
    n_cmp++; if (dout !== 32'h04030201 || level !== LW'(1)) begin n_err++; $display("FAIL rst_resume: got %h level=%0d want 04030201/1", dout, level); end
  endtask

  task automatic test_random();
    bit md, v, lst, wr_n;
    for (int i = 0; i < 600; i++) begin
      md   = ($urandom_range(0, 199) != 0);
      v    = ($urandom_range(0, 3) != 0);
      lst  = ($urandom_range(0, 7) == 0);
      wr_n = (i < 300) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 2) != 0);
      drive_cycle(md, v, 8'($urandom), lst, wr_n);
      n_cmp++;
      if (level !== exp_level() || dout !== exp_data() || avail !== (m_q.size() > 0) ||
          b_ready !== exp_ready() || drop !== m_drop || unf !== m_unf) begin
        n_err++;
        $display("FAIL rand%0d: got lvl=%0d data=%h rdy=%b drop=%b unf=%b want lvl=%0d data=%h rdy=%b drop=%b unf=%b",
                 i, level, dout, b_ready, drop, unf, exp_level(), exp_data(), exp_ready(), m_drop, m_unf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pack_basic();
    test_last_pad();
    test_full_drop();
    test_commit_pop();
    test_underflow_mode();
    test_reset_midword();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
